// File: rtl/fpr_cdb_arb.sv
// Floating-point CDB arbiter: round-robin grant among FPR-writing units,
// one-cycle registered broadcast of {valid, tag, data} on the FPR CDB.

package fpr_cdb_pkg;
  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;
endpackage

module fpr_cdb_arb
  import fpr_cdb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [ROB_WIDTH-1:0] req_tag    [N_REQ],
  input  logic [31:0]          req_result [N_REQ],
  output cdb_t                 fpr_cdb
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic                 gnt_v_q, gnt_v_d;
  logic [ROB_WIDTH-1:0] tag_q, tag_d;

  logic                 found;
  int                   scan;
  logic [IDX_W-1:0]     scan_idx;

  // Round-robin scan from ptr; first valid requester wins, nothing while in reset
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    scan      = 0;
    scan_idx  = '0;
    gnt_idx_d = gnt_idx_q;
    for (int i = 0; i < N_REQ; i++) begin
      scan = int'(ptr_q) + i;
      if (scan >= N_REQ) scan = scan - N_REQ;
      scan_idx = IDX_W'(scan);
      if (!found && !reset && req_valid[scan_idx]) begin
        req_ready[scan_idx] = 1'b1;
        found               = 1'b1;
        gnt_idx_d           = scan_idx;
      end
    end
  end

  // Next-state for grant registers and pointer; pointer moves past the winner
  always_comb begin
    gnt_v_d = found;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    if (found) begin
      tag_d = req_tag[gnt_idx_d];
      ptr_d = (gnt_idx_d == LAST_IDX) ? '0 : gnt_idx_d + 1'b1;
    end
  end

  // Grant capture with synchronous reset; a pending grant is dropped by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      gnt_v_q   <= 1'b0;
      gnt_idx_q <= '0;
      tag_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_v_q   <= gnt_v_d;
      gnt_idx_q <= gnt_idx_d;
      tag_q     <= tag_d;
    end
  end

  // Broadcast purely from registered state; data taken from the granted unit's result register
  always_comb begin
    fpr_cdb.valid = gnt_v_q;
    fpr_cdb.tag   = tag_q;
    fpr_cdb.data  = req_result[gnt_idx_q];
  end

endmodule

// File: tb/tb_fpr_cdb_arb.sv
// Bench for fpr_cdb_arb: directed scenarios plus random traffic against a
// queue-based reference model of the arbitration and broadcast rules.

module tb_fpr_cdb_arb;
  import fpr_cdb_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [ROB_WIDTH-1:0] req_tag    [N];
  logic [31:0]          req_result [N];
  cdb_t                 fpr_cdb;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int                   idx;
    logic [ROB_WIDTH-1:0] tag;
  } bcast_t;

  bcast_t exp_q[$];
  int     m_ptr = 0;
  int     wait_cnt[N];

  fpr_cdb_arb #(.N_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tag    (req_tag),
    .req_result (req_result),
    .fpr_cdb    (fpr_cdb)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // First valid index in rotating order from p, or -1 when none
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge
  task automatic cycle();
    bcast_t       b;
    int           g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g       = reset ? -1 : rr_pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("ready", 64'(req_ready), 64'(exp_rdy));
    check_val("ptr", 64'(dut.ptr_q), 64'(m_ptr));
    if (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      check_val("cdb_valid", 64'(fpr_cdb.valid), 64'd1);
      check_val("cdb_tag", 64'(fpr_cdb.tag), 64'(b.tag));
      check_val("cdb_data", 64'(fpr_cdb.data), 64'(req_result[b.idx]));
    end else begin
      check_val("cdb_valid", 64'(fpr_cdb.valid), 64'd0);
    end
    for (int k = 0; k < N; k++) begin
      if (reset || !req_valid[k]) begin
        wait_cnt[k] = 0;
      end else if (req_ready[k]) begin
        check_val("fair", 64'(wait_cnt[k] < N), 64'd1);
        wait_cnt[k] = 0;
      end else begin
        wait_cnt[k]++;
        if (wait_cnt[k] == N) check_val("starve", 64'(wait_cnt[k]), 64'(N - 1));
      end
    end
    @(posedge clk);
    if (reset) begin
      m_ptr = 0;
    end else if (g >= 0) begin
      exp_q.push_back('{g, req_tag[g]});
      m_ptr = (g + 1) % N;
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic [N-1:0] v;
    reset     = 1'b1;
    req_valid = '1;
    for (int k = 0; k < N; k++) begin
      req_tag[k]    = '0;
      req_result[k] = '0;
      wait_cnt[k]   = 0;
    end
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset     = 1'b0;
    req_valid = '0;
    cycle();

    // single requester
    req_valid  = 4'b0100;
    req_tag[2] = 6'd5;
    cycle();
    req_valid     = '0;
    req_result[2] = 32'h3F80_0000;
    cycle();
    check_val("tp_ptr3", 64'(dut.ptr_q), 64'd3);

    // all four from reset, tags 0..3
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_tag[k]    = ROB_WIDTH'(k);
      req_result[k] = 32'h4000_1000 + 32'(k);
    end
    req_valid = 4'hf;
    repeat (4) cycle();
    req_valid = '0;
    cycle();

    // wrap-around from ptr=3 with units 0 and 3
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b1001;
    repeat (2) cycle();
    req_valid = '0;
    cycle();

    // idle
    repeat (3) cycle();

    // reset mid-flight
    req_valid  = 4'b0010;
    req_tag[1] = 6'd7;
    cycle();
    reset = 1'b1;
    repeat (2) cycle();
    reset     = 1'b0;
    req_valid = 4'b0011;
    cycle();
    req_valid = '0;
    cycle();

    // fairness: unit 0 always, unit 3 joins and holds
    req_valid = 4'b0001;
    repeat (3) cycle();
    req_valid = 4'b1001;
    repeat (5) cycle();
    req_valid = '0;
    cycle();

    // random traffic with sticky requests and occasional reset
    v = '0;
    repeat (3000) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) v[k] = ~v[k];
        req_tag[k]    = ROB_WIDTH'($urandom);
        req_result[k] = $urandom;
      end
      req_valid = v;
      reset     = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset     = 1'b0;
    req_valid = '0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpr_cdb_arb.md
Name: fpr_cdb_arb

Overview:
- Floating-point common data bus (CDB) arbiter, directly downstream of the FPR-writing execution units (fmov, fadd, fmul, finv, ...).
- Each cycle it grants at most one requester via its req_if valid/ready pair.
- It captures the granted ROB tag, then broadcasts {valid, tag, data} on the FPR CDB one cycle later. The data comes from the granted unit's registered result.
- The CDB output feeds reservation-station wakeup, the ROB and the FPR file.

Parameters:
- N_REQ, 4, number of requesting units (≥2). Index 0 is fmov by convention of the top level.
- ROB_WIDTH, common.vh global, ROB tag width (not overridable here).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- req_valid[N_REQ]  in  1 each  unit has a result ready to dispatch (req_if.valid)
- req_ready[N_REQ]  out  1 each  grant (req_if.ready); dispatch = valid && ready
- req_tag[N_REQ]  in  ROB_WIDTH each  tag of the dispatching entry; valid in the request cycle
- req_result[N_REQ]  in  32 each  unit result register; valid in the cycle after grant
- fpr_cdb  out  cdb_t  broadcast: .valid, .tag (ROB_WIDTH), .data (32)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - fpr_cdb.valid = 0
  - round-robin pointer ptr = 0
  - all req_ready = 0 in any cycle where reset is high, even if req_valid is high
- Grant logic (combinational, same cycle):
  - Scan indices ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ).
  - req_ready[k] = 1 only for the first k with req_valid[k] = 1; all others 0.
  - Exactly one ready when any valid is high; none when no valid is high.
  - req_ready never asserts for an index whose valid is low.
- Registered state updated on a grant to k at edge t:
  - gnt_v_q <= 1
  - gnt_idx_q <= k
  - tag_q <= req_tag[k]
  - ptr <= (k+1) mod N_REQ, with wrap at N_REQ-1 → 0
- No grant at edge t: gnt_v_q <= 0; ptr and gnt_idx_q hold.
- Broadcast in cycle t+1:
  - fpr_cdb.valid = gnt_v_q
  - fpr_cdb.tag = tag_q
  - fpr_cdb.data = req_result[gnt_idx_q] (combinational mux from registered index only)
  - tag and data are don't-care (x permitted) when valid = 0.
- Latency: grant → broadcast is exactly 1 cycle. Throughput is 1 broadcast per cycle; back-to-back grants to different units or to the same unit are allowed.
- No combinational path from any req_valid or req_tag to fpr_cdb. This is mandatory, because units compute req_valid from fpr_cdb wakeup.
- Fairness: a unit holding req_valid continuously is granted within N_REQ cycles.
- Simultaneous events:
  - All N_REQ requesting: grants rotate in index order starting at ptr.
  - A unit may request in the same cycle its previous result is broadcast; this is legal and independent.
- Reset mid-operation:
  - A grant registered before reset rose is discarded; fpr_cdb.valid = 0 in the cycle after the reset edge.
  - No grant is issued while reset is high.
  - ptr returns to 0.
- The block performs no data modification (sign handling is done in the units).

Test Plan (N_REQ=4):
- Single requester: req_valid[2]=1, tag=5 at cycle 1; result=0x3F800000 at cycle 2.
  → req_ready[2]=1 at cycle 1.
  → cycle 2: fpr_cdb = {1, 5, 0x3F800000}.
  → ptr=3.
- All four valid for 4 cycles from reset, tags 0..3.
  → grants in order 0,1,2,3.
  → CDB tags 0,1,2,3 on cycles 2..5, each with the matching unit's result.
- Wrap-around: ptr=3 with units 0 and 3 requesting.
  → grant 3, then 0.
  → ptr sequence 3→0→1.
- Idle: no req_valid for 3 cycles.
  → all ready=0; fpr_cdb.valid=0 for those cycles; ptr unchanged.
- Reset mid-flight: grant to unit 1 (tag 7) at cycle 4, reset high at cycle 4 edge with req_valid[1]=1 held.
  → cycle 5: fpr_cdb.valid=0, req_ready all 0 while reset high.
  → first grant after reset goes to unit 0 if it is requesting.
- Fairness: unit 0 requests every cycle; unit 3 asserts valid at cycle 10 and holds.
  → unit 3 is granted no later than cycle 13, and its tag appears on the CDB the next cycle.
